regfile_write_arbiter: RTL and testbench

- Sole controller of the register-file write port: sequences the active-low E/clr controls of NUM_REGS 32-bit registers.
- After reset, sweeps a clear through every register, one per cycle.
- Then arbitrates between two writeback requesters with round-robin priority: req0 = ALU writeback, req1 = load writeback.
- Drives registered one-hot active-low enables, shared clear and write data to the register bank.

---
 rtl/regfile_write_arbiter_pkg.sv | 22 ++
 rtl/regfile_write_arbiter_rr_arbiter2.sv | 51 +++++
 rtl/regfile_write_arbiter.sv | 139 +++++++++++++
 tb/tb_regfile_write_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port controller:
// controller state encoding, default geometry and the idle enable pattern.
package regfile_write_arbiter_pkg;

    // Default bank geometry (overridable per instance)
    localparam int NUM_REGS_DEF = 16;
    localparam int ADDR_W_DEF   = 4;
    localparam int DATA_W_DEF   = 32;

    // Widest bank the idle constant covers (ADDR_W up to 8)
    localparam int MAX_REGS = 256;

    // Idle pattern for the active-low per-register enables: nothing selected
    localparam logic [MAX_REGS-1:0] REG_E_N_IDLE = {MAX_REGS{1'b1}};

    // Controller states: clear sweep after reset / clear_req, then normal writes
    typedef enum logic [0:0] {
        ST_SWEEP = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-input round-robin grant. A lone request is always granted; when both
// request, the pointer picks the winner. After an accepted grant the pointer
// moves to the other requester so the loser wins next time.
module rr_arbiter2 (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic ptr_q;
    logic ptr_d;

    // Grant selection: gated by en_i, ties broken by the pointer
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   gnt_o = 2'b01;
                2'b10:   gnt_o = 2'b10;
                2'b11:   gnt_o = ptr_q ? 2'b10 : 2'b01;
                default: gnt_o = 2'b00;
            endcase
        end else begin
            gnt_o = 2'b00;
        end
    end

    // Pointer advance: a grant always implies an accepted transfer
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Pointer register; requester 0 is favoured out of reset
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sole owner of the register-file write port. Out of reset (or on clear_req)
// it walks a clear through every register one per cycle, then arbitrates
// the ALU (wb0) and load (wb1) writeback streams round-robin. All bank
// controls are registered; the ready handshakes are combinational.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int NUM_REGS = NUM_REGS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                wb0_valid,
    input  logic [ADDR_W-1:0]   wb0_addr,
    input  logic [DATA_W-1:0]   wb0_data,
    output logic                wb0_ready,
    input  logic                wb1_valid,
    input  logic [ADDR_W-1:0]   wb1_addr,
    input  logic [DATA_W-1:0]   wb1_data,
    output logic                wb1_ready,
    input  logic                clear_req,
    output logic [NUM_REGS-1:0] reg_E_n,
    output logic                reg_clr_n,
    output logic [DATA_W-1:0]   reg_D,
    output logic                init_done
);

    // Sweep index must be able to hold NUM_REGS itself (the "sweep finished" value)
    localparam int               IDX_W     = $clog2(NUM_REGS + 1);
    localparam logic [IDX_W-1:0] SWEEP_END = IDX_W'(NUM_REGS);
    localparam logic [NUM_REGS-1:0] E_N_IDLE = REG_E_N_IDLE[NUM_REGS-1:0];

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [NUM_REGS-1:0]  e_n_q, e_n_d;
    logic                 clr_n_q, clr_n_d;
    logic [DATA_W-1:0]    data_q, data_d;
    logic                 init_done_q, init_done_d;

    logic                 arb_en_s;
    logic [1:0]           gnt_s;

    // One-hot active-low select; out-of-range addresses select nothing
    function automatic logic [NUM_REGS-1:0] dec_n(input logic [31:0] sel);
        logic [NUM_REGS-1:0] v;
        v = E_N_IDLE;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel == 32'(i)) begin
                v[i] = 1'b0;
            end else begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // A clear request in RUN pre-empts any grant in the same cycle
    assign arb_en_s = (state_q == ST_RUN) && !clear_req;

    rr_arbiter2 u_rr (
        .clk_i  (clk),
        .rst_ni (clr),
        .en_i   (arb_en_s),
        .req_i  ({wb1_valid, wb0_valid}),
        .gnt_o  (gnt_s)
    );

    assign wb0_ready = gnt_s[0];
    assign wb1_ready = gnt_s[1];

    // Next-state and next-output logic for sweep and write arbitration
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        e_n_d       = E_N_IDLE;
        clr_n_d     = 1'b1;
        data_d      = data_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_SWEEP: begin
                if (idx_q != SWEEP_END) begin
                    e_n_d   = dec_n(32'(idx_q));
                    clr_n_d = 1'b0;
                    data_d  = {DATA_W{1'b0}};
                    idx_d   = idx_q + IDX_W'(1);
                end else begin
                    state_d     = ST_RUN;
                    init_done_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (clear_req) begin
                    state_d     = ST_SWEEP;
                    idx_d       = {IDX_W{1'b0}};
                    init_done_d = 1'b0;
                end else if (gnt_s[0]) begin
                    e_n_d  = dec_n(32'(wb0_addr));
                    data_d = wb0_data;
                end else if (gnt_s[1]) begin
                    e_n_d  = dec_n(32'(wb1_addr));
                    data_d = wb1_data;
                end else begin
                    e_n_d = E_N_IDLE;
                end
            end
            default: begin
                state_d     = ST_SWEEP;
                idx_d       = {IDX_W{1'b0}};
                init_done_d = 1'b0;
            end
        endcase
    end

    // State and registered bank controls; reset forces everything idle at once
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_SWEEP;
            idx_q       <= {IDX_W{1'b0}};
            e_n_q       <= E_N_IDLE;
            clr_n_q     <= 1'b1;
            data_q      <= {DATA_W{1'b0}};
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            e_n_q       <= e_n_d;
            clr_n_q     <= clr_n_d;
            data_q      <= data_d;
            init_done_q <= init_done_d;
        end
    end

    assign reg_E_n   = e_n_q;
    assign reg_clr_n = clr_n_q;
    assign reg_D     = data_q;
    assign init_done = init_done_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: the stimulus thread pushes the
// expected bank-control word for every write it expects, a monitor thread
// pops and compares whenever an enable is low. A behavioural bank model
// checks the values that land in the registers.
module tb_regfile_write_arbiter;

    localparam int NR = 16;
    localparam int AW = 5;
    localparam int DW = 32;

    typedef struct packed {
        logic [NR-1:0] e_n;
        logic          clr_n;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          clr;
    logic          wb0_valid, wb1_valid, wb0_ready, wb1_ready;
    logic [AW-1:0] wb0_addr, wb1_addr;
    logic [DW-1:0] wb0_data, wb1_data;
    logic          clear_req;
    logic [NR-1:0] reg_E_n;
    logic          reg_clr_n;
    logic [DW-1:0] reg_D;
    logic          init_done;

    logic [NR-1:0] idle_c;
    logic [DW-1:0] bank [NR];
    logic          preload;
    wr_t           exp_q[$];
    int            checks   = 0;
    int            failures = 0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .clr       (clr),
        .wb0_valid (wb0_valid),
        .wb0_addr  (wb0_addr),
        .wb0_data  (wb0_data),
        .wb0_ready (wb0_ready),
        .wb1_valid (wb1_valid),
        .wb1_addr  (wb1_addr),
        .wb1_data  (wb1_data),
        .wb1_ready (wb1_ready),
        .clear_req (clear_req),
        .reg_E_n   (reg_E_n),
        .reg_clr_n (reg_clr_n),
        .reg_D     (reg_D),
        .init_done (init_done)
    );

    // Register bank model: E low + clr_n low clears, E low + clr_n high loads D
    always @(posedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (preload) bank[i] <= 32'hDEADBEEF;
            else if (!reg_E_n[i]) bank[i] <= reg_clr_n ? reg_D : 32'h0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                         input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        wb0_valid = v0; wb0_addr = a0; wb0_data = d0;
        wb1_valid = v1; wb1_addr = a1; wb1_data = d1;
    endtask

    task automatic push_wr(input int addr, input logic [DW-1:0] data, input logic clr_n);
        wr_t w;
        w.e_n       = '1;
        w.e_n[addr] = 1'b0;
        w.clr_n     = clr_n;
        w.d         = data;
        exp_q.push_back(w);
    endtask

    task automatic push_sweep();
        for (int i = 0; i < NR; i++) push_wr(i, 32'h0, 1'b0);
    endtask

    task automatic check_rdy(input string name, input logic [1:0] exp);
        check(name, 64'({wb1_ready, wb0_ready}), 64'(exp));
    endtask

    initial begin
        wr_t got;
        logic [NR-1:0] e9;
        logic any_nz;
        idle_c = '1;
        clr = 1'b0; preload = 1'b1; clear_req = 1'b0;
        drive(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);

        // Monitor: every low enable must match the oldest expected write
        fork
            forever begin
                @(negedge clk);
                if (clr === 1'b1 && reg_E_n !== idle_c) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_write", 64'({reg_E_n, reg_clr_n, reg_D}), 64'({idle_c, 1'b1, reg_D}));
                    end else begin
                        got = exp_q.pop_front();
                        check("write_ctl", 64'({reg_E_n, reg_clr_n, reg_D}), 64'(got));
                    end
                end
            end
        join_none

        // Reset state, with both requesters asking
        repeat (2) @(posedge clk);
        #2;
        check("rst_E_n", 64'(reg_E_n), 64'(idle_c));
        check("rst_clr_n", 64'(reg_clr_n), 64'h1);
        check("rst_D", 64'(reg_D), 64'h0);
        check("rst_init_done", 64'(init_done), 64'h0);
        check_rdy("rst_ready", 2'b00);

        // Release: 16-cycle clear sweep, RUN from edge 17
        clr = 1'b1; preload = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        push_sweep();
        repeat (16) tick();
        check("sweep_init_low", 64'(init_done), 64'h0);
        tick();
        check("sweep_init_high", 64'(init_done), 64'h1);
        check("sweep_drained", 64'(exp_q.size()), 64'h0);
        any_nz = 1'b0;
        for (int i = 0; i < NR; i++) if (bank[i] != 32'h0) any_nz = 1'b1;
        check("bank_cleared", 64'(any_nz), 64'h0);

        // Lone wb0 write to R3
        drive(1'b1, 5'd3, 32'h12345678, 1'b0, 5'd0, 32'h0);
        #1 check_rdy("wb0_alone", 2'b01);
        push_wr(3, 32'h12345678, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check("bank_r3", 64'(bank[3]), 64'h12345678);

        // Lone wb1 write to R4; pointer returns to wb0
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
        #1 check_rdy("wb1_alone", 2'b10);
        push_wr(4, 32'h44, 1'b1);
        tick();

        // Both valid every cycle: grants alternate 0,1,0,1
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd1, 32'hA, 1'b1, 5'd2, 32'hB);
            #1;
            if (k % 2 == 0) begin
                check_rdy("alt_grant0", 2'b01);
                push_wr(1, 32'hA, 1'b1);
            end else begin
                check_rdy("alt_grant1", 2'b10);
                push_wr(2, 32'hB, 1'b1);
            end
            tick();
        end

        // Same address from both: wb0 first, wb1 wins the final value
        drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 32'h2);
        #1 check_rdy("same_addr_first", 2'b01);
        push_wr(5, 32'h1, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h2);
        #1 check_rdy("same_addr_second", 2'b10);
        push_wr(5, 32'h2, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        check("bank_r5_first", 64'(bank[5]), 64'h1);
        tick();
        check("bank_r5_final", 64'(bank[5]), 64'h2);

        // clear_req pre-empts a pending wb1 write, which completes after the sweep
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);
        clear_req = 1'b1;
        #1 check_rdy("clear_blocks_wb1", 2'b00);
        tick();
        clear_req = 1'b0;
        #1 check("clear_init_drop", 64'(init_done), 64'h0);
        check_rdy("sweep_no_ready", 2'b00);
        push_sweep();
        repeat (16) tick();
        check("resweep_init_low", 64'(init_done), 64'h0);
        check_rdy("resweep_no_ready", 2'b00);
        tick();
        check("resweep_init_high", 64'(init_done), 64'h1);
        check_rdy("wb1_after_sweep", 2'b10);
        push_wr(7, 32'h77, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check("bank_r7", 64'(bank[7]), 64'h77);

        // Async reset in the middle of a sweep (idx 9 on the bus)
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        push_sweep();
        repeat (10) tick();
        e9 = '1; e9[9] = 1'b0;
        check("sweep_at_idx9", 64'(reg_E_n), 64'(e9));
        clr = 1'b0;
        #1;
        check("async_rst_E_n", 64'(reg_E_n), 64'(idle_c));
        check("async_rst_clr_n", 64'(reg_clr_n), 64'h1);
        check("async_rst_init", 64'(init_done), 64'h0);
        check("sweep_progress", 64'(exp_q.size()), 64'd7);
        exp_q.delete();
        tick();
        clr = 1'b1;
        push_sweep();
        repeat (16) tick();
        check("restart_init_low", 64'(init_done), 64'h0);
        tick();
        check("restart_init_high", 64'(init_done), 64'h1);

        // Out-of-range address: accepted, no enable, pointer still advances
        drive(1'b1, 5'd20, 32'h99, 1'b0, 5'd0, 32'h0);
        #1 check_rdy("oor_accept", 2'b01);
        tick();
        drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd2, 32'h66);
        #1 check_rdy("oor_ptr_toggled", 2'b10);
        push_wr(2, 32'h66, 1'b1);
        tick();
        drive(1'b1, 5'd1, 32'h55, 1'b0, 5'd0, 32'h0);
        #1 check_rdy("loser_served", 2'b01);
        push_wr(1, 32'h55, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) tick();
        check("bank_r1", 64'(bank[1]), 64'h55);
        check("bank_r2", 64'(bank[2]), 64'h66);
        check("scoreboard_drained", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
